// File: rtl/adpll_lock_ctrl_if.sv
// Purpose  : board-control / ADPLL-pin bundle for the ADPLL lock sequencer.
// Latency  : plain wires; all timing is owned by the sequencer that drives the outputs.
// Backpres.: none; level/strobe signals only, no handshake.
// Signals  : start, ref_clk, error (towards sequencer);
//            loop_rst, loop_en, locked, lock_lost, ref_missing, state,
//            relock_cnt, retry_cnt (from sequencer).
interface adpll_lock_ctrl_if #(
  parameter int ERR_WIDTH = 8
);
  logic                        start;
  logic                        ref_clk;
  logic signed [ERR_WIDTH-1:0] error;
  logic                        loop_rst;
  logic                        loop_en;
  logic                        locked;
  logic                        lock_lost;
  logic                        ref_missing;
  logic [1:0]                  state;
  logic [7:0]                  relock_cnt;
  logic [7:0]                  retry_cnt;

  // master: board / testbench side
  modport master (
    output start, ref_clk, error,
    input  loop_rst, loop_en, locked, lock_lost, ref_missing, state, relock_cnt, retry_cnt
  );

  // slave: the lock sequencer
  modport slave (
    input  start, ref_clk, error,
    output loop_rst, loop_en, locked, lock_lost, ref_missing, state, relock_cnt, retry_cnt
  );
endinterface

// File: rtl/adpll_lock_ctrl.sv
// Purpose  : ADPLL lock sequencer/monitor: resets, enables and supervises the loop, declares
//            lock, detects loss of lock and loss of reference, and re-acquires automatically.
// Latency  : all outputs registered; ref edge seen 3 fpga_clk cycles after ref rise, state
//            change visible 1 cycle after the causing event.
// Backpres.: none; start is a level, ref/error are sampled free-running.
// Ports    : fpga_clk_i, reset_i (async, active high); ctl_io (slave modport) carries
//            start/ref_clk/error in and loop_rst/loop_en/locked/lock_lost/ref_missing/
//            state/relock_cnt/retry_cnt out.
// Option   : define ADPLL_LOCK_STATS_EN to build the relock/retry statistics counters;
//            without it both counters read constant 0.
module adpll_lock_ctrl #(
  parameter int ERR_WIDTH     = 8,
  parameter int LOCK_THRESH   = 2,
  parameter int UNLOCK_THRESH = 8,
  parameter int LOCK_COUNT    = 64,
  parameter int UNLOCK_COUNT  = 4,
  parameter int ACQ_TIMEOUT   = 4096,
  parameter int RST_CYCLES    = 16,
  parameter int REF_TIMEOUT   = 1024,
  parameter int CNT_WIDTH     = 16
) (
  input logic               fpga_clk_i,
  input logic               reset_i,
  adpll_lock_ctrl_if.slave  ctl_io
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RESET_LOOP = 2'd1,
    ST_ACQUIRE    = 2'd2,
    ST_LOCKED     = 2'd3
  } state_e;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  localparam logic [ERR_WIDTH-1:0] ERR_MIN = {1'b1, {(ERR_WIDTH-1){1'b0}}};
  localparam logic [ERR_WIDTH-1:0] ERR_MAX = {1'b0, {(ERR_WIDTH-1){1'b1}}};

  // Reference synchroniser: two metastability flops plus a delay flop for edge detection.
  logic ref_s1_q, ref_s2_q, ref_s3_q;
  logic ref_edge;

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      ref_s1_q <= 1'b0;
      ref_s2_q <= 1'b0;
      ref_s3_q <= 1'b0;
    end else begin
      ref_s1_q <= ctl_io.ref_clk;
      ref_s2_q <= ref_s1_q;
      ref_s3_q <= ref_s2_q;
    end
  end

  assign ref_edge = ref_s2_q & ~ref_s3_q;

  // Magnitude of the phase error; the most negative code has no positive twin and saturates.
  logic [ERR_WIDTH-1:0] err_raw;
  logic [ERR_WIDTH-1:0] abs_err;
  logic                 good_smp, bad_smp;

  assign err_raw = ctl_io.error;

  always_comb begin
    abs_err = err_raw;
    if (err_raw[ERR_WIDTH-1]) begin
      abs_err = (err_raw == ERR_MIN) ? ERR_MAX : (~err_raw + 1'b1);
    end
  end

  assign good_smp = (abs_err <= ERR_WIDTH'(LOCK_THRESH));
  assign bad_smp  = (abs_err >  ERR_WIDTH'(UNLOCK_THRESH));

  state_e state_q, state_d;
  cnt_t   cyc_q, cyc_d, edge_q, edge_d, good_q, good_d, bad_q, bad_d, wd_q, wd_d;
  cnt_t   edge_inc, good_nxt, bad_nxt, wd_inc;
  logic   wd_fire;
  logic   loop_rst_q, loop_rst_d, loop_en_q, loop_en_d, locked_q, locked_d;
  logic   lost_q, lost_d, miss_q, miss_d;

  assign edge_inc = edge_q + 1'b1;
  assign wd_inc   = wd_q + 1'b1;
  assign good_nxt = good_smp ? cnt_t'(good_q + 1'b1) : '0;
  assign bad_nxt  = bad_smp  ? cnt_t'(bad_q + 1'b1)  : '0;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    edge_d  = edge_q;
    good_d  = good_q;
    bad_d   = bad_q;
    wd_d    = '0;
    wd_fire = 1'b0;
    lost_d  = 1'b0;
    miss_d  = ref_edge ? 1'b0 : miss_q;

    // Reference watchdog runs whenever the loop is not parked.
    if (state_q != ST_IDLE) begin
      if (ref_edge) begin
        wd_d = '0;
      end else if (wd_inc == cnt_t'(REF_TIMEOUT)) begin
        wd_fire = 1'b1;
        wd_d    = '0;
      end else begin
        wd_d = wd_inc;
      end
    end

    case (state_q)
      ST_IDLE: begin
        cyc_d = '0;
        if (ctl_io.start) state_d = ST_RESET_LOOP;
      end
      ST_RESET_LOOP: begin
        if (wd_fire) begin
          miss_d = 1'b1;
          cyc_d  = '0;    // restart the reset window
        end else if (cyc_q == cnt_t'(RST_CYCLES - 1)) begin
          state_d = ST_ACQUIRE;
          edge_d  = '0;
          good_d  = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_ACQUIRE: begin
        if (wd_fire) begin
          state_d = ST_RESET_LOOP;
          miss_d  = 1'b1;
          cyc_d   = '0;
        end else if (ref_edge) begin
          edge_d = edge_inc;
          good_d = good_nxt;
          // Lock is tested first so a coinciding timeout edge loses.
          if (good_nxt == cnt_t'(LOCK_COUNT)) begin
            state_d = ST_LOCKED;
            bad_d   = '0;
          end else if (edge_inc == cnt_t'(ACQ_TIMEOUT)) begin
            state_d = ST_RESET_LOOP;
            cyc_d   = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (wd_fire) begin
          state_d = ST_RESET_LOOP;
          miss_d  = 1'b1;
          lost_d  = 1'b1;
          cyc_d   = '0;
        end else if (ref_edge) begin
          bad_d = bad_nxt;  // errors between thresholds clear the run without counting
          if (bad_nxt == cnt_t'(UNLOCK_COUNT)) begin
            state_d = ST_ACQUIRE;
            lost_d  = 1'b1;
            edge_d  = '0;
            good_d  = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Dropping start parks the loop immediately and silently.
    if (!ctl_io.start) begin
      state_d = ST_IDLE;
      lost_d  = 1'b0;
    end

    loop_rst_d = (state_d == ST_IDLE) || (state_d == ST_RESET_LOOP);
    loop_en_d  = (state_d == ST_ACQUIRE) || (state_d == ST_LOCKED);
    locked_d   = (state_d == ST_LOCKED);
  end

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      cyc_q      <= '0;
      edge_q     <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      wd_q       <= '0;
      loop_rst_q <= 1'b1;
      loop_en_q  <= 1'b0;
      locked_q   <= 1'b0;
      lost_q     <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      edge_q     <= edge_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      wd_q       <= wd_d;
      loop_rst_q <= loop_rst_d;
      loop_en_q  <= loop_en_d;
      locked_q   <= locked_d;
      lost_q     <= lost_d;
      miss_q     <= miss_d;
    end
  end

`ifdef ADPLL_LOCK_STATS_EN
  logic [7:0] relock_q, retry_q;
  logic       retry_evt;

  // Only a genuine acquisition timeout counts as a retry, not a watchdog restart.
  assign retry_evt = (state_q == ST_ACQUIRE) && (state_d == ST_RESET_LOOP) && !wd_fire;

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      relock_q <= '0;
      retry_q  <= '0;
    end else begin
      if (lost_d && (relock_q != 8'hFF)) relock_q <= relock_q + 1'b1;
      if (retry_evt && (retry_q != 8'hFF)) retry_q <= retry_q + 1'b1;
    end
  end

  assign ctl_io.relock_cnt = relock_q;
  assign ctl_io.retry_cnt  = retry_q;
`else
  assign ctl_io.relock_cnt = 8'd0;
  assign ctl_io.retry_cnt  = 8'd0;
`endif

  assign ctl_io.state       = state_q;
  assign ctl_io.loop_rst    = loop_rst_q;
  assign ctl_io.loop_en     = loop_en_q;
  assign ctl_io.locked      = locked_q;
  assign ctl_io.lock_lost   = lost_q;
  assign ctl_io.ref_missing = miss_q;

endmodule
